hazard_ctrl: RTL and testbench

Central hazard controller for the five-stage MIPS pipeline. It tracks the destination register and remaining result latency (Tnew) of every in-flight instruction in E, M and W. From these records it decides each cycle whether the ID-stage instruction must stall, and it drives the operand-forwarding selects for the ID comparator/NPC and the E-stage ALU. It also sequences the shared multiply/divide unit with a busy counter, so HI/LO consumers and new mult/div issues wait until the unit is free.

---
 rtl/hazard_ctrl.sv | 140 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall decision, ID/E forwarding selects, mult/div busy sequencing.
// Outputs are combinational from the E/M/W records and ID inputs; records and md counter update on rising clk.
module hazard_ctrl #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic [1:0] id_tuse_rs,
    input  logic [1:0] id_tuse_rt,
    input  logic [4:0] id_wa,
    input  logic [1:0] id_tnew,
    input  logic       id_md_start,
    input  logic       id_md_div,
    input  logic       id_md_use,
    output logic       stall,
    output logic [1:0] fwd_rs_d,
    output logic [1:0] fwd_rt_d,
    output logic [1:0] fwd_rs_e,
    output logic [1:0] fwd_rt_e,
    output logic       md_busy
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_LAT);

    localparam logic [1:0] TUSE_NONE = 2'd3;
    localparam logic [1:0] FWD_SRC   = 2'd0;
    localparam logic [1:0] FWD_M     = 2'd1;
    localparam logic [1:0] FWD_E_D   = 2'd2;
    localparam logic [1:0] FWD_W_E   = 2'd2;

    logic [4:0]       e_wa_q, e_wa_d;
    logic [1:0]       e_tnew_q, e_tnew_d;
    logic [4:0]       e_rs_q, e_rs_d;
    logic [4:0]       e_rt_q, e_rt_d;
    logic [4:0]       m_wa_q, m_wa_d;
    logic [1:0]       m_tnew_q, m_tnew_d;
    logic [4:0]       w_wa_q, w_wa_d;
    logic [CNT_W-1:0] md_cnt_q, md_cnt_d;

    function automatic logic src_hazard(
        input logic [4:0] s, input logic [1:0] tuse,
        input logic [4:0] ewa, input logic [1:0] etnew,
        input logic [4:0] mwa, input logic [1:0] mtnew
    );
        logic hit;
        hit = 1'b0;
        if (tuse != TUSE_NONE && s != 5'd0) begin
            hit = (ewa == s && etnew > tuse) || (mwa == s && mtnew > tuse);
        end
        return hit;
    endfunction

    // ID-stage forwarding only sees results already computed; W reaches ID via GRF write-through.
    function automatic logic [1:0] fwd_id(
        input logic [4:0] s,
        input logic [4:0] ewa, input logic [1:0] etnew,
        input logic [4:0] mwa, input logic [1:0] mtnew
    );
        logic [1:0] sel;
        sel = FWD_SRC;
        if (s != 5'd0 && ewa == s && etnew == 2'd0) begin
            sel = FWD_E_D;
        end else if (s != 5'd0 && mwa == s && mtnew == 2'd0) begin
            sel = FWD_M;
        end
        return sel;
    endfunction

    function automatic logic [1:0] fwd_ex(
        input logic [4:0] s,
        input logic [4:0] mwa, input logic [1:0] mtnew,
        input logic [4:0] wwa
    );
        logic [1:0] sel;
        sel = FWD_SRC;
        if (s != 5'd0 && mwa == s && mtnew == 2'd0) begin
            sel = FWD_M;
        end else if (s != 5'd0 && wwa == s) begin
            sel = FWD_W_E;
        end
        return sel;
    endfunction

    always_comb begin
        md_busy  = (md_cnt_q != '0);
        stall    = src_hazard(id_rs, id_tuse_rs, e_wa_q, e_tnew_q, m_wa_q, m_tnew_q)
                 | src_hazard(id_rt, id_tuse_rt, e_wa_q, e_tnew_q, m_wa_q, m_tnew_q)
                 | ((id_md_use | id_md_start) & md_busy);
        fwd_rs_d = fwd_id(id_rs, e_wa_q, e_tnew_q, m_wa_q, m_tnew_q);
        fwd_rt_d = fwd_id(id_rt, e_wa_q, e_tnew_q, m_wa_q, m_tnew_q);
        fwd_rs_e = fwd_ex(e_rs_q, m_wa_q, m_tnew_q, w_wa_q);
        fwd_rt_e = fwd_ex(e_rt_q, m_wa_q, m_tnew_q, w_wa_q);
    end

    // A stalled ID instruction becomes an all-zero bubble so it is recorded only once it leaves ID.
    always_comb begin
        e_wa_d   = stall ? 5'd0 : id_wa;
        e_tnew_d = stall ? 2'd0 : id_tnew;
        e_rs_d   = stall ? 5'd0 : id_rs;
        e_rt_d   = stall ? 5'd0 : id_rt;
        m_wa_d   = e_wa_q;
        m_tnew_d = (e_tnew_q != 2'd0) ? e_tnew_q - 2'd1 : 2'd0;
        w_wa_d   = m_wa_q;
        md_cnt_d = md_cnt_q;
        if (!stall && id_md_start) begin
            md_cnt_d = id_md_div ? DIV_LD : MULT_LD;
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e_wa_q   <= '0;
            e_tnew_q <= '0;
            e_rs_q   <= '0;
            e_rt_q   <= '0;
            m_wa_q   <= '0;
            m_tnew_q <= '0;
            w_wa_q   <= '0;
            md_cnt_q <= '0;
        end else begin
            e_wa_q   <= e_wa_d;
            e_tnew_q <= e_tnew_d;
            e_rs_q   <= e_rs_d;
            e_rt_q   <= e_rt_d;
            m_wa_q   <= m_wa_d;
            m_tnew_q <= m_tnew_d;
            w_wa_q   <= w_wa_d;
            md_cnt_q <= md_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: instruction-level pipeline model checked every cycle plus directed hand-computed checks.
module tb_hazard_ctrl;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic       clk, rst;
    logic [4:0] id_rs, id_rt, id_wa;
    logic [1:0] id_tuse_rs, id_tuse_rt, id_tnew;
    logic       id_md_start, id_md_div, id_md_use;
    logic       stall, md_busy;
    logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;

    hazard_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_tuse_rs(id_tuse_rs), .id_tuse_rt(id_tuse_rt),
        .id_wa(id_wa), .id_tnew(id_tnew),
        .id_md_start(id_md_start), .id_md_div(id_md_div), .id_md_use(id_md_use),
        .stall(stall),
        .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d),
        .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e),
        .md_busy(md_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    typedef struct {
        logic [4:0] rs, rt, wa;
        logic [1:0] tur, tut, tnew;
        logic       ms, md, mu;
    } id_t;

    function automatic id_t mk(input int rs, input int tur, input int rt, input int tut,
                               input int wa, input int tnew, input int ms, input int md, input int mu);
        id_t i;
        i.rs = 5'(rs); i.tur = 2'(tur); i.rt = 5'(rt); i.tut = 2'(tut);
        i.wa = 5'(wa); i.tnew = 2'(tnew);
        i.ms = 1'(ms); i.md = 1'(md); i.mu = 1'(mu);
        return i;
    endfunction

    task automatic apply(input id_t i);
        id_rs = i.rs; id_rt = i.rt; id_tuse_rs = i.tur; id_tuse_rt = i.tut;
        id_wa = i.wa; id_tnew = i.tnew;
        id_md_start = i.ms; id_md_div = i.md; id_md_use = i.mu;
    endtask

    // Model: in-flight instructions indexed by pipeline distance from E (0=E,1=M,2=W),
    // each remembering the Tnew it had on entering E; remaining latency = that minus distance.
    logic [4:0] mw[3], mrs[3], mrt[3];
    int         mt[3];
    int         cyc_n   = 0;
    int         md_free = 0;

    function automatic int remain(input int k);
        return (mt[k] - k > 0) ? mt[k] - k : 0;
    endfunction

    function automatic bit src_hz(input logic [4:0] s, input logic [1:0] tu);
        if (tu == 2'd3 || s == 5'd0) return 1'b0;
        for (int k = 0; k < 2; k++)
            if (mw[k] == s && remain(k) > int'(tu)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit model_busy();
        return cyc_n < md_free;
    endfunction

    function automatic bit model_stall();
        return src_hz(id_rs, id_tuse_rs) || src_hz(id_rt, id_tuse_rt)
            || ((id_md_use || id_md_start) && model_busy());
    endfunction

    function automatic int model_fwd_d(input logic [4:0] s);
        if (s == 5'd0) return 0;
        if (mw[0] == s && remain(0) == 0) return 2;
        if (mw[1] == s && remain(1) == 0) return 1;
        return 0;
    endfunction

    function automatic int model_fwd_e(input logic [4:0] s);
        if (s == 5'd0) return 0;
        if (mw[1] == s && remain(1) == 0) return 1;
        if (mw[2] == s) return 2;
        return 0;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 3; k++) begin
                mw[k] = '0; mrs[k] = '0; mrt[k] = '0; mt[k] = 0;
            end
            md_free = 0;
        end else begin
            bit st;
            st = model_stall();
            for (int k = 2; k > 0; k--) begin
                mw[k] = mw[k-1]; mrs[k] = mrs[k-1]; mrt[k] = mrt[k-1]; mt[k] = mt[k-1];
            end
            mw[0]  = st ? 5'd0 : id_wa;
            mrs[0] = st ? 5'd0 : id_rs;
            mrt[0] = st ? 5'd0 : id_rt;
            mt[0]  = st ? 0 : int'(id_tnew);
            cyc_n++;
            if (!st && id_md_start) md_free = cyc_n + (id_md_div ? DIV_LAT : MULT_LAT);
        end
    end

    always @(negedge clk) begin
        chk("model_stall",    int'(stall),    int'(model_stall()));
        chk("model_md_busy",  int'(md_busy),  int'(model_busy()));
        chk("model_fwd_rs_d", int'(fwd_rs_d), model_fwd_d(id_rs));
        chk("model_fwd_rt_d", int'(fwd_rt_d), model_fwd_d(id_rt));
        chk("model_fwd_rs_e", int'(fwd_rs_e), model_fwd_e(mrs[0]));
        chk("model_fwd_rt_e", int'(fwd_rt_e), model_fwd_e(mrt[0]));
    end

    task automatic cyc(input id_t i);
        @(posedge clk); #1;
        apply(i);
        @(negedge clk); #1;
    endtask

    // Holds an ID instruction until the DUT releases it; returns the stall cycle count.
    task automatic hold_count(input id_t i, output int n);
        n = 0;
        cyc(i);
        while (stall === 1'b1 && n < 30) begin
            n++;
            cyc(i);
        end
    endtask

    id_t nop, lw1, addu2, addu4, beq4, jal, jr31, mult, divi, mflo, lw5, addu6, lw10, mthi10;
    id_t addu7, subu7, zprod, zcons;
    int  n;

    initial begin
        nop    = mk(0, 3, 0, 3, 0, 0, 0, 0, 0);
        lw1    = mk(9, 1, 0, 3, 1, 2, 0, 0, 0);
        addu2  = mk(1, 1, 3, 1, 2, 1, 0, 0, 0);
        addu4  = mk(5, 1, 6, 1, 4, 1, 0, 0, 0);
        beq4   = mk(4, 0, 0, 0, 0, 0, 0, 0, 0);
        jal    = mk(0, 3, 0, 3, 31, 0, 0, 0, 0);
        jr31   = mk(31, 0, 0, 3, 0, 0, 0, 0, 0);
        mult   = mk(7, 1, 8, 1, 0, 0, 1, 0, 0);
        divi   = mk(7, 1, 8, 1, 0, 0, 1, 1, 0);
        mflo   = mk(0, 3, 0, 3, 9, 1, 0, 0, 1);
        lw5    = mk(9, 1, 0, 3, 5, 2, 0, 0, 0);
        addu6  = mk(5, 1, 3, 1, 6, 1, 0, 0, 0);
        lw10   = mk(9, 1, 0, 3, 10, 2, 0, 0, 0);
        mthi10 = mk(10, 1, 0, 3, 0, 0, 0, 0, 1);
        addu7  = mk(11, 1, 12, 1, 7, 1, 0, 0, 0);
        subu7  = mk(13, 1, 7, 1, 14, 1, 0, 0, 0);
        zprod  = mk(0, 1, 0, 1, 0, 2, 0, 0, 0);
        zcons  = mk(0, 0, 0, 0, 0, 1, 0, 0, 0);

        rst = 1'b0;
        apply(addu2);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_stall", int'(stall), 0);
        chk("reset_md_busy", int'(md_busy), 0);
        chk("reset_fwd_rs_d", int'(fwd_rs_d), 0);
        chk("reset_fwd_rs_e", int'(fwd_rs_e), 0);
        rst = 1'b1;
        apply(nop);

        // lw then dependent ALU op: one stall, then W->E forward
        cyc(lw1);   chk("lw_issue_stall", int'(stall), 0);
        cyc(addu2); chk("lw_use_stall", int'(stall), 1);
        cyc(addu2); chk("lw_use_release", int'(stall), 0);
        cyc(nop);   chk("lw_fwd_rs_e_w", int'(fwd_rs_e), 2);
        repeat (3) cyc(nop);

        // ALU producer then branch using it in ID
        cyc(addu4);
        cyc(beq4); chk("beq_stall", int'(stall), 1);
        cyc(beq4); chk("beq_release", int'(stall), 0);
        chk("beq_fwd_rs_d_m", int'(fwd_rs_d), 1);
        repeat (3) cyc(nop);

        cyc(jal);
        cyc(jr31); chk("jr_stall", int'(stall), 0);
        chk("jr_fwd_rs_d_e", int'(fwd_rs_d), 2);
        repeat (3) cyc(nop);

        // M->E forward on the rt path
        cyc(addu7);
        cyc(subu7); chk("subu_stall", int'(stall), 0);
        cyc(nop);   chk("subu_fwd_rt_e_m", int'(fwd_rt_e), 1);
        repeat (3) cyc(nop);

        cyc(mult);
        cyc(mflo); chk("mult_busy_first", int'(md_busy), 1);
        n = 1;
        while (stall === 1'b1 && n < 30) begin n++; cyc(mflo); end
        chk("mult_mflo_stall_cycles", n - 1, MULT_LAT);
        chk("mult_done_busy", int'(md_busy), 0);
        repeat (2) cyc(nop);

        cyc(divi);
        hold_count(mflo, n);
        chk("div_mflo_stall_cycles", n, DIV_LAT);
        repeat (2) cyc(nop);

        // mult then div back to back; div loads on the edge it leaves ID
        cyc(mult);
        hold_count(divi, n);
        chk("mult_div_stall_cycles", n, MULT_LAT);
        cyc(nop); chk("div_loaded_busy", int'(md_busy), 1);
        hold_count(mflo, n);
        chk("div_after_mult_mflo_stall", n, DIV_LAT - 1);
        repeat (2) cyc(nop);

        // data and md hazards overlapping: single stall released when both clear
        cyc(mult);
        cyc(lw10);
        hold_count(mthi10, n);
        chk("combined_stall_cycles", n, MULT_LAT - 1);
        repeat (3) cyc(nop);

        // asynchronous reset mid-stall and mid-md
        cyc(mult);
        cyc(lw5);
        cyc(addu6); chk("pre_reset_stall", int'(stall), 1);
        chk("pre_reset_busy", int'(md_busy), 1);
        rst = 1'b0;
        #1;
        chk("async_reset_stall", int'(stall), 0);
        chk("async_reset_busy", int'(md_busy), 0);
        chk("async_reset_fwd_rs_d", int'(fwd_rs_d), 0);
        chk("async_reset_fwd_rs_e", int'(fwd_rs_e), 0);
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        chk("post_reset_stall", int'(stall), 0);
        cyc(addu6); chk("post_reset_addu_stall", int'(stall), 0);
        repeat (3) cyc(nop);

        // $0 never matches
        cyc(zprod);
        cyc(zcons); chk("zero_stall", int'(stall), 0);
        chk("zero_fwd_rs_d", int'(fwd_rs_d), 0);
        chk("zero_fwd_rt_d", int'(fwd_rt_d), 0);
        cyc(zcons); chk("zero_fwd_rs_e", int'(fwd_rs_e), 0);
        chk("zero_fwd_rt_e", int'(fwd_rt_e), 0);
        repeat (2) cyc(nop);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
